// File: rtl/game_pkg.sv
// Shared definitions for the game stages: state encoding, score width and default win score.
package game_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PLAYING = 2'd1,
        WON     = 2'd2,
        LOST    = 2'd3
    } game_state_t;

    localparam int SCORE_W           = 4;
    localparam int DEFAULT_WIN_SCORE = 10;

    function automatic logic is_game_over(input game_state_t s);
        return (s == WON) || (s == LOST);
    endfunction

endpackage

// File: rtl/blink_timer.sv
// Half-period counter that toggles o_Toggle every BLINK_CYCLES enabled cycles; disabled means counter and toggle held at 0.
module blink_timer #(
    parameter int BLINK_CYCLES = 12500000
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    output logic o_Toggle
);

    localparam int CNT_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BLINK_CYCLES - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count    <= '0;
            o_Toggle <= 1'b0;
        end else if (!enable) begin
            count    <= '0;
            o_Toggle <= 1'b0;
        end else if (count == LAST) begin
            count    <= '0;
            o_Toggle <= ~o_Toggle;
        end else begin
            count    <= count + 1'b1;
        end
    end

endmodule

// File: rtl/score_keeper.sv
// Game FSM and score register; drives the score display and blanks it while a finished game is shown.
module score_keeper
    import game_pkg::*;
#(
    parameter int WIN_SCORE    = DEFAULT_WIN_SCORE,
    parameter int BLINK_CYCLES = 12500000
) (
    input  logic               i_Clk,
    input  logic               i_Rst,
    input  logic               i_Start,
    input  logic               i_Round_Won,
    input  logic               i_Round_Lost,
    output logic [SCORE_W-1:0] o_Score,
    output logic [1:0]         o_State,
    output logic               o_Level_Up,
    output logic               o_Game_Over,
    output logic               o_Blank
);

    localparam logic [SCORE_W-1:0] WIN = SCORE_W'(WIN_SCORE);

    game_state_t state;
    logic        blink_en;

    // A start in a finished game must clear the blink in the same edge that leaves WON/LOST.
    assign blink_en = is_game_over(state) && !i_Start;
    assign o_State  = state;

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state       <= IDLE;
            o_Score     <= '0;
            o_Level_Up  <= 1'b0;
            o_Game_Over <= 1'b0;
        end else begin
            o_Level_Up <= 1'b0;
            if (i_Start) begin
                state       <= PLAYING;
                o_Score     <= '0;
                o_Game_Over <= 1'b0;
            end else begin
                case (state)
                    PLAYING: begin
                        if (i_Round_Lost) begin
                            state       <= LOST;
                            o_Game_Over <= 1'b1;
                        end else if (i_Round_Won) begin
                            o_Score    <= o_Score + 1'b1;
                            o_Level_Up <= 1'b1;
                            if (o_Score + 1'b1 == WIN) begin
                                state       <= WON;
                                o_Game_Over <= 1'b1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    blink_timer #(
        .BLINK_CYCLES(BLINK_CYCLES)
    ) u_blink (
        .clk     (i_Clk),
        .rst     (i_Rst),
        .enable  (blink_en),
        .o_Toggle(o_Blank)
    );

endmodule

// File: tb/tb_score_keeper.sv
// Bench for score_keeper: behavioural game model compared every cycle, plus directed literal checks.
module tb_score_keeper;

    localparam int WIN = 10;
    localparam int BLK = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       won = 1'b0;
    logic       lost = 1'b0;
    logic [3:0] score;
    logic [1:0] state;
    logic       level_up;
    logic       game_over;
    logic       blank;

    int n_cmp = 0;
    int n_err = 0;

    score_keeper #(.WIN_SCORE(WIN), .BLINK_CYCLES(BLK)) dut (
        .i_Clk       (clk),
        .i_Rst       (rst),
        .i_Start     (start),
        .i_Round_Won (won),
        .i_Round_Lost(lost),
        .o_Score     (score),
        .o_State     (state),
        .o_Level_Up  (level_up),
        .o_Game_Over (game_over),
        .o_Blank     (blank)
    );

    always #5 clk = ~clk;

    // Model: state 0..3, score, cycles spent in the finished game
    int m_state = 0;
    int m_score = 0;
    int m_since = 0;
    int m_lvl   = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_state = 0; m_score = 0; m_since = 0; m_lvl = 0;
        end else begin
            m_lvl = 0;
            if (start) begin
                m_state = 1; m_score = 0; m_since = 0;
            end else if (m_state == 1) begin
                if (lost) begin
                    m_state = 3; m_since = 0;
                end else if (won) begin
                    m_score = m_score + 1; m_lvl = 1;
                    if (m_score == WIN) begin
                        m_state = 2; m_since = 0;
                    end
                end
            end else if (m_state >= 2) begin
                m_since = m_since + 1;
            end
        end
    end

    function automatic int m_blank();
        return (m_state >= 2) ? ((m_since / BLK) % 2) : 0;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("mdl_score", int'(score), m_score);
        check("mdl_state", int'(state), m_state);
        check("mdl_level_up", int'(level_up), m_lvl);
        check("mdl_game_over", int'(game_over), (m_state >= 2) ? 1 : 0);
        check("mdl_blank", int'(blank), m_blank());
    end

    task automatic pulse(input logic s, input logic w, input logic l);
        @(posedge clk); #1;
        start = s; won = w; lost = l;
        @(posedge clk); #1;
        start = 0; won = 0; lost = 0;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    int lvl_seen;
    int blink_exp [9] = '{0, 0, 0, 0, 1, 1, 1, 1, 0};

    initial begin
        #1 rst = 1;
        idle_cycles(2);
        check("rst_score", int'(score), 0);
        check("rst_state", int'(state), 0);
        check("rst_flags", int'({level_up, game_over, blank}), 0);
        rst = 0;

        pulse(0, 1, 0);
        check("idle_ignore_won", int'(score), 0);
        check("idle_state", int'(state), 0);

        pulse(1, 0, 0);
        check("start_state", int'(state), 1);
        check("start_score", int'(score), 0);
        lvl_seen = 0;
        for (int i = 1; i <= 3; i++) begin
            pulse(0, 1, 0);
            check("win_score", int'(score), i);
            lvl_seen += int'(level_up);
        end
        check("level_up_count", lvl_seen, 3);
        check("three_wins_state", int'(state), 1);

        pulse(0, 1, 0);
        pulse(0, 1, 1);
        check("both_state", int'(state), 3);
        check("both_score", int'(score), 4);
        check("both_no_level_up", int'(level_up), 0);
        check("blink_seq0", int'(blank), blink_exp[0]);
        for (int i = 1; i < 9; i++) begin
            @(posedge clk); #1;
            check("blink_seq", int'(blank), blink_exp[i]);
        end
        idle_cycles(4);
        check("blank_high_lost", int'(blank), 1);
        pulse(0, 1, 0);
        check("lost_ignore_won", int'(score), 4);
        pulse(1, 0, 0);
        check("restart_blank", int'(blank), 0);
        check("restart_score", int'(score), 0);
        check("restart_state", int'(state), 1);

        for (int i = 0; i < 7; i++) pulse(0, 1, 0);
        check("score_seven", int'(score), 7);
        pulse(1, 1, 0);
        check("start_win_score", int'(score), 0);
        check("start_win_state", int'(state), 1);
        check("start_win_no_lvl", int'(level_up), 0);

        for (int i = 0; i < 10; i++) pulse(0, 1, 0);
        check("ten_score", int'(score), 10);
        check("ten_state", int'(state), 2);
        check("ten_game_over", int'(game_over), 1);
        pulse(0, 1, 0);
        check("eleventh_score", int'(score), 10);
        idle_cycles(2);
        check("won_blank_high", int'(blank), 1);
        #3 rst = 1;
        #1;
        check("async_rst_state", int'(state), 0);
        check("async_rst_outs", int'({score, level_up, game_over, blank}), 0);
        idle_cycles(1);
        rst = 0;
        pulse(0, 1, 0);
        pulse(0, 1, 0);
        check("post_rst_score", int'(score), 0);
        check("post_rst_state", int'(state), 0);
        idle_cycles(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/score_keeper.md
SCORE_KEEPER -- requirements
Module: Score_Keeper

Interface
REQ-001 The block SHALL have parameter WIN_SCORE, default 10, meaning the score that ends the game as a win; legal range 1..15.
REQ-002 The block SHALL have parameter BLINK_CYCLES, default 12500000, meaning the clock cycles per display blink half-period (0.5 s at 25 MHz).
REQ-003 Port i_Clk  input  1  is the single clock; every register is clocked on its rising edge.
REQ-004 Port i_Rst  input  1  is the reset, asynchronous and active-high.
REQ-005 Port i_Start  input  1  is a one-cycle pulse that starts or restarts a game.
REQ-006 Port i_Round_Won  input  1  is a one-cycle pulse meaning the player completed the current round.
REQ-007 Port i_Round_Lost  input  1  is a one-cycle pulse meaning the player failed the current round.
REQ-008 Port o_Score  output  4  is the current score, which feeds the seven-segment display stage directly.
REQ-009 Port o_State  output  2  is the game state: IDLE=0, PLAYING=1, WON=2, LOST=3.
REQ-010 Port o_Level_Up  output  1  is a one-cycle pulse on each score increment.
REQ-011 Port o_Game_Over  output  1  is high in WON or LOST.
REQ-012 Port o_Blank  output  1  means the display is blanked; it toggles while the game is over.

Function
REQ-013 All outputs SHALL be registered; each output SHALL change exactly one cycle after the input edge that causes the change.
REQ-014 IDLE: o_Score=0; i_Start moves to PLAYING with o_Score=0; i_Round_Won and i_Round_Lost SHALL be ignored.
REQ-015 PLAYING, i_Round_Won: o_Score increments by 1 and o_Level_Up pulses for 1 cycle; if the new score equals WIN_SCORE, the state moves to WON in the same cycle.
REQ-016 PLAYING, i_Round_Lost: the state moves to LOST and o_Score holds its value.
REQ-017 If i_Round_Won and i_Round_Lost are high in the same cycle, the loss SHALL take priority: no increment, no o_Level_Up.
REQ-018 If i_Start is high in any state, the start SHALL take priority over win/loss: state becomes PLAYING, o_Score=0, o_Blank=0, blink counter cleared, no o_Level_Up.
REQ-019 WON/LOST: o_Score SHALL be held; i_Round_Won and i_Round_Lost SHALL be ignored; only i_Start or reset leaves these states.
REQ-020 Score arithmetic SHALL be 4-bit unsigned; o_Score SHALL never exceed WIN_SCORE and SHALL never wrap.
REQ-021 On entry to WON/LOST, o_Blank=0 and the blink counter starts at 0; o_Blank SHALL toggle when the counter reaches BLINK_CYCLES-1, and the counter then returns to 0.
REQ-022 o_Blank SHALL be 0 in IDLE and PLAYING; the blink counter SHALL be held at 0 outside WON/LOST.
REQ-023 o_Game_Over SHALL equal (o_State==WON)|(o_State==LOST) as a registered value, aligned with o_State.

Reset
REQ-024 Asserting i_Rst SHALL immediately force: state IDLE, o_Score=0, o_Level_Up=0, o_Game_Over=0, o_Blank=0, blink counter 0.
REQ-025 Reset asserted mid-game or mid-blink SHALL discard the score; after release the block SHALL stay in IDLE until i_Start.

Structure
REQ-026 State encodings (IDLE, PLAYING, WON, LOST) and the default WIN_SCORE SHALL live in the shared package Game_Pkg, used by all game stages.
REQ-027 The blink counter and toggle SHALL be the sub-module Blink_Timer (ports: clock, reset, enable, output o_Toggle; parameter BLINK_CYCLES), instantiated once.
REQ-028 The score register and FSM SHALL stay in Score_Keeper.

Verification
REQ-029 Reset, then i_Start, then 3 i_Round_Won pulses -> o_Score 0,1,2,3 one cycle after each pulse; 3 o_Level_Up pulses; o_State=PLAYING.
REQ-030 WIN_SCORE=10, 10 win pulses -> o_Score=10, o_State=WON and o_Game_Over=1 in the same cycle; an 11th pulse leaves o_Score=10.
REQ-031 At score 4, i_Round_Won and i_Round_Lost together -> o_State=LOST, o_Score=4, no o_Level_Up.
REQ-032 BLINK_CYCLES=4 in LOST -> o_Blank sequence 0,0,0,0,1,1,1,1,0...; i_Start -> o_Blank=0, o_Score=0, o_State=PLAYING.
REQ-033 i_Start and i_Round_Won together at score 7 -> o_Score=0, o_State=PLAYING, no o_Level_Up.
REQ-034 i_Rst asserted asynchronously in WON while o_Blank=1 -> all outputs 0 and o_State=IDLE before the next clock edge; win pulses after release are ignored.
